bus_master_arbiter: RTL

- Shares the single system bus between the pipeline-side masters: the IF controller's uncached fetch and cache-error-buffer refill, the MEM controller, I-cache refill and D-cache writeback/refill.
- Grants one owner at a time and muxes that owner's address, strobe, rw and write data onto the bus.
- Returns ready and read data to the owner.
- A watchdog converts a hung transfer into a per-master bus error, which feeds if_bus_error and the MEM-stage equivalent.

---
 rtl/bus_master_arbiter_pkg.sv | 40 ++++
 rtl/bus_master_arbiter_prio_select.sv | 48 ++++
 rtl/bus_master_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// bus_master_arbiter_pkg
// Shared definitions for the system bus arbiter: FSM state encodings,
// master index assignments, bus direction / grant / error level constants,
// and a small modular index helper used by the round-robin selector.
// Ports: none (package).
package bus_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE  = 2'd0,
    ARB_STATE_BUSY  = 2'd1,
    ARB_STATE_ERROR = 2'd2
  } arb_state_t;

  localparam int MASTER_IF     = 0;
  localparam int MASTER_MEM    = 1;
  localparam int MASTER_ICACHE = 2;
  localparam int MASTER_DCACHE = 3;

  localparam logic BUS_RW_READ       = 1'b1;
  localparam logic BUS_RW_WRITE      = 1'b0;
  localparam logic GRANT_ENABLE      = 1'b1;
  localparam logic GRANT_DISABLE     = 1'b0;
  localparam logic BUS_ERROR_ENABLE  = 1'b1;
  localparam logic BUS_ERROR_DISABLE = 1'b0;

  // Width of a master index; never zero so a single-master build still
  // has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + offset) mod n, for base and offset already below n.
  function automatic int wrap_add(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/bus_master_arbiter_prio_select.sv
// bus_arb_prio_select
// Combinational winner selection among the requesting masters.
// Default build: fixed priority, index 0 highest.
// With BUS_ARB_ROUND_ROBIN_EN defined: round robin, the search starts at
// 'ptr' and wraps, so the master at 'ptr' has the highest priority.
// Ports:
//   req     in   NUM_MASTERS  request vector
//   ptr     in   IDX_W        round-robin start index (ignored when fixed)
//   winner  out  IDX_W        index of the selected master (0 if none)
//   any_req out  1            at least one request is pending
module bus_arb_prio_select
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Scan from the farthest offset back to the pointer so the requester
  // closest to the pointer (offset 0 first) overwrites the others.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(ptr), k, NUM_MASTERS)])
        winner = IDX_W'(wrap_add(int'(ptr), k, NUM_MASTERS));
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downward so the lowest requesting index is the last written.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter
// Shares the single system bus between the pipeline-side masters. One owner
// at a time is granted; its address/strobe/direction/write data are muxed
// onto the bus, and bus ready is routed back to it alone. A watchdog turns a
// transfer that never sees bus_rdy into a one-cycle bus error for the owner.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; undefined gives fixed priority (index 0 highest).
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   m_req/m_as/m_rw    per-master request, strobe, direction (1 = read)
//   m_addr/m_wdata     per-master address / write data, packed by index
//   m_grant            registered one-hot grant
//   m_rdy/m_rdata      ready to the owner only / broadcast read data
//   m_bus_error        one-cycle watchdog error pulse to the owner
//   bus_*              muxed bus outputs, slave ready and read data in
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [NUM_MASTERS-1:0]        m_rdy,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_bus_error,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic                          bus_as,
  output logic                          bus_rw,
  output logic [DATA_W-1:0]             bus_wdata,
  input  logic                          bus_rdy,
  input  logic [DATA_W-1:0]             bus_rdata
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] ptr;
  logic             any_req;
  logic [7:0]       watchdog;
  logic             wd_fire;

  bus_arb_prio_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_select (
    .req     (m_req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Priority pointer moves to the slot just after each new owner, so the
  // master that was just served drops to lowest priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (state == ARB_STATE_IDLE && any_req) begin
      ptr <= IDX_W'(wrap_add(int'(winner), 1, NUM_MASTERS));
    end
  end
`else
  assign ptr = '0;
`endif

  // Bus outputs follow the owner only while a grant is live; otherwise the
  // bus is parked at zero with the strobe low.
  always_comb begin
    bus_as    = 1'b0;
    bus_addr  = '0;
    bus_rw    = 1'b0;
    bus_wdata = '0;
    m_rdy     = '0;
    if (state == ARB_STATE_BUSY) begin
      bus_as        = m_as[owner];
      bus_addr      = m_addr[int'(owner)*ADDR_W +: ADDR_W];
      bus_rw        = m_rw[owner];
      bus_wdata     = m_wdata[int'(owner)*DATA_W +: DATA_W];
      m_rdy[owner]  = bus_rdy;
    end
  end

  assign m_rdata = bus_rdata;

  // The watchdog fires on the last stalled cycle; a ready in that same
  // cycle suppresses it because bus_rdy is part of the condition.
  assign wd_fire = (state == ARB_STATE_BUSY) && bus_as && !bus_rdy &&
                   (watchdog == 8'(TIMEOUT_CYCLES - 1));

  // Arbitration FSM. IDLE always lasts at least one cycle between owners,
  // which gives the bus a turnaround cycle. A release by the owner takes
  // precedence over a watchdog expiry in the same cycle, since there is no
  // longer anyone to report the error to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ARB_STATE_IDLE;
      m_grant     <= '0;
      owner       <= '0;
      watchdog    <= '0;
      m_bus_error <= '0;
    end else begin
      m_bus_error <= '0;
      case (state)
        ARB_STATE_IDLE: begin
          watchdog <= '0;
          if (any_req) begin
            m_grant         <= '0;
            m_grant[winner] <= GRANT_ENABLE;
            owner           <= winner;
            state           <= ARB_STATE_BUSY;
          end
        end
        ARB_STATE_BUSY: begin
          if (!m_req[owner]) begin
            m_grant  <= '0;
            watchdog <= '0;
            state    <= ARB_STATE_IDLE;
          end else if (wd_fire) begin
            m_grant            <= '0;
            watchdog           <= '0;
            m_bus_error[owner] <= BUS_ERROR_ENABLE;
            state              <= ARB_STATE_ERROR;
          end else if (bus_as && !bus_rdy) begin
            watchdog <= watchdog + 8'd1;
          end else begin
            watchdog <= '0;
          end
        end
        ARB_STATE_ERROR: begin
          state <= ARB_STATE_IDLE;
        end
        default: begin
          m_grant <= '0;
          state   <= ARB_STATE_IDLE;
        end
      endcase
    end
  end

endmodule
